// File: rtl/dependence_arb_pkg.sv
// Shared definitions for the dependence-unit arbiter: FSM encoding, defaults and a
// width helper usable in parameter expressions.
package dependence_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/dependence_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
// Kept generic so other shared-resource controllers can reuse it.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        any   = |valid;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/dependence_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle dependence unit among N
// requesters, with a watchdog that aborts an operation whose done never arrives.
//
// state | meaning
// IDLE  | waiting for a request; grant, latch operands and requester id
// ISSUE | one-cycle start pulse to the unit, watchdog cleared
// WAIT  | waiting for unit_done or watchdog expiry
// RESP  | response presented until rsp_ready
module dependence_arbiter
    import dependence_arb_pkg::*;
#(
    parameter  int N       = 2,
    parameter  int W       = 1,
    parameter  int RW      = 1,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int IW      = (clog2(N) > 1) ? clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_valid,
    output logic [N-1:0]  req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N*W-1:0] req_c,
    output logic          unit_start,
    output logic [W-1:0]  unit_a,
    output logic [W-1:0]  unit_b,
    output logic [W-1:0]  unit_c,
    input  logic          unit_done,
    input  logic [RW-1:0] unit_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [IW-1:0] rsp_id,
    output logic [RW-1:0] rsp_result,
    output logic          rsp_err,
    output logic          busy
);

    localparam int CW = clog2(TIMEOUT + 1);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] ptr;
    logic [CW-1:0] wd;
    logic [N-1:0]  grant;
    logic [IW-1:0] gidx;
    logic          any;
    logic          expired;
    logic          take;

    rr_pick #(.N(N), .PW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    assign expired = (wd == CW'(TIMEOUT - 1));
    assign take    = (state == ST_IDLE) && any;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        unit_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    req_ready = grant;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                unit_start = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (unit_done || expired) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            wd         <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            unit_c     <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (take) begin
                unit_a <= req_a[int'(gidx)*W +: W];
                unit_b <= req_b[int'(gidx)*W +: W];
                unit_c <= req_c[int'(gidx)*W +: W];
                rsp_id <= gidx;
                ptr    <= IW'((int'(gidx) + 1) % N);
            end

            if (state == ST_ISSUE)
                wd <= '0;
            else if (state == ST_WAIT && wd != CW'(TIMEOUT))
                wd <= wd + 1'b1;

            // done on the expiry cycle takes precedence over the abort
            if (state == ST_WAIT) begin
                if (unit_done) begin
                    rsp_result <= unit_result;
                    rsp_err    <= 1'b0;
                end else if (expired) begin
                    rsp_result <= '0;
                    rsp_err    <= 1'b1;
                end
            end
        end
    end

endmodule
